pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. Merges per-stage stall requests into the 4-bit stall vector that every pipeline register consumes: bit0 inst, bit1 id, bit2 exe, bit3 data. Takes precise exceptions and ERET from the MEM stage and issues a one-cycle flush with redirect PC. Handles the draining of an in-flight instruction-bus read that the flush has orphaned.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_ctrl_stall_perf_cnt.sv | 37 +++
 rtl/pipe_ctrl.sv | 70 +++++++
 tb/tb_pipe_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control constants, stall bit indices and FSM state encoding.
package pipe_ctrl_pkg;
   localparam logic        RST_ENABLE     = 1'b1;
   localparam logic        EXCEPTION_ON   = 1'b1;
   localparam int          EXCEP_TYPE_BUS = 32;
   localparam logic [31:0] ERET_CODE_DEF  = 32'h0000000E;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
   localparam int          STALL_INST     = 0;
   localparam int          STALL_ID       = 1;
   localparam int          STALL_EXE      = 2;
   localparam int          STALL_DATA     = 3;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_DATA = 2'd1, DRAIN = 2'd2} state_e;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall requests, MEM exception info and ibus status in; stall/flush/redirect out.
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;
   logic                      req_inst_stall;
   logic                      req_id_stall;
   logic                      req_exe_stall;
   logic                      req_data_stall;
   logic [EXCEP_TYPE_BUS-1:0] mem_excep_type;
   logic [31:0]               cp0_epc;
   logic                      ibus_outstanding;
   logic                      ibus_rvalid;
   logic [3:0]                stall;
   logic                      exception;
   logic [31:0]               new_pc;
   logic                      discard_inst;
   modport master (
      output req_inst_stall, req_id_stall, req_exe_stall, req_data_stall,
             mem_excep_type, cp0_epc, ibus_outstanding, ibus_rvalid,
      input  stall, exception, new_pc, discard_inst
   );
   modport slave (
      input  req_inst_stall, req_id_stall, req_exe_stall, req_data_stall,
             mem_excep_type, cp0_epc, ibus_outstanding, ibus_rvalid,
      output stall, exception, new_pc, discard_inst
   );
endinterface

// File: rtl/pipe_ctrl_stall_perf_cnt.sv
// pipe_ctrl_stall_perf_cnt: free-running stall/flush counters, built only with PIPE_PERF_CNT_EN.
module pipe_ctrl_stall_perf_cnt
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  stall_i,
   input  logic        flush_i,
   output logic [31:0] perf_inst_o,
   output logic [31:0] perf_id_o,
   output logic [31:0] perf_exe_o,
   output logic [31:0] perf_data_o,
   output logic [31:0] perf_flush_o
);
   logic [31:0] inst_q, id_q, exe_q, data_q, flush_q;
   // The stall vector is a thermometer code, so "highest bit set" is this bit set and the next one clear.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         inst_q  <= '0;
         id_q    <= '0;
         exe_q   <= '0;
         data_q  <= '0;
         flush_q <= '0;
      end else begin
         inst_q  <= inst_q + {31'd0, stall_i[STALL_INST] & ~stall_i[STALL_ID]};
         id_q    <= id_q + {31'd0, stall_i[STALL_ID] & ~stall_i[STALL_EXE]};
         exe_q   <= exe_q + {31'd0, stall_i[STALL_EXE] & ~stall_i[STALL_DATA]};
         data_q  <= data_q + {31'd0, stall_i[STALL_DATA]};
         flush_q <= flush_q + {31'd0, flush_i};
      end
   end
   assign perf_inst_o  = inst_q;
   assign perf_id_o    = id_q;
   assign perf_exe_o   = exe_q;
   assign perf_data_o  = data_q;
   assign perf_flush_o = flush_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge plus precise-exception/ERET flush sequencer with orphaned-ibus drain.
// Optional PIPE_PERF_CNT_EN adds the perf_* stall/flush counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
   parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] perf_inst,
   output logic [31:0] perf_id,
   output logic [31:0] perf_exe,
   output logic [31:0] perf_data,
   output logic [31:0] perf_flush
`endif
);
   state_e      state_q, state_d;
   logic        exception_q, exception_d, fire, pending;
   logic [31:0] new_pc_q, new_pc_d;
   logic [3:0]  stall_v;
   // The MEM register is being cleared while the pulse is out, so its type is stale then.
   assign pending = |bus.mem_excep_type && !exception_q;
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q     <= IDLE;
         exception_q <= 1'b0;
         new_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         exception_q <= exception_d;
         new_pc_q    <= new_pc_d;
      end
   end
   always_comb begin
      fire    = pending && (state_q == DRAIN || !bus.req_data_stall);
      state_d = state_q == DRAIN ? ((fire || !bus.ibus_rvalid) ? DRAIN : IDLE)
              : (pending && bus.req_data_stall) ? WAIT_DATA
              : (fire && bus.ibus_outstanding && !bus.ibus_rvalid) ? DRAIN : IDLE;
   end
   always_comb begin
      stall_v[STALL_DATA] = bus.req_data_stall;
      stall_v[STALL_EXE]  = bus.req_exe_stall | stall_v[STALL_DATA];
      stall_v[STALL_ID]   = bus.req_id_stall | stall_v[STALL_EXE];
      stall_v[STALL_INST] = bus.req_inst_stall | stall_v[STALL_ID] | (state_q == DRAIN);
      exception_d         = fire ? EXCEPTION_ON : ~EXCEPTION_ON;
      new_pc_d            = !fire ? new_pc_q
                          : bus.mem_excep_type == ERET_CODE ? bus.cp0_epc : EXC_VECTOR;
   end
   assign bus.stall        = stall_v;
   assign bus.exception    = exception_q;
   assign bus.new_pc       = new_pc_q;
   assign bus.discard_inst = state_q == DRAIN;
`ifdef PIPE_PERF_CNT_EN
   pipe_ctrl_stall_perf_cnt u_perf (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_v),
      .flush_i      (exception_q),
      .perf_inst_o  (perf_inst),
      .perf_id_o    (perf_id),
      .perf_exe_o   (perf_exe),
      .perf_data_o  (perf_data),
      .perf_flush_o (perf_flush)
   );
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + random stimulus; per-cycle expectations and redirect PCs are queued
// by the driver and consumed by an independent negedge monitor.
module tb_pipe_ctrl;
   localparam logic [31:0] VEC  = 32'hBFC00380;
   localparam logic [31:0] ERET = 32'h0000000E;
   typedef struct packed {
      logic [3:0] stall;
      logic       disc;
      logic       exc;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   pipe_ctrl_if bus_if ();
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] perf_inst, perf_id, perf_exe, perf_data, perf_flush;
   int unsigned m_inst = 0, m_id = 0, m_exe = 0, m_data = 0, m_flush = 0;
`endif
   pipe_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_if)
`ifdef PIPE_PERF_CNT_EN
      ,
      .perf_inst  (perf_inst),
      .perf_id    (perf_id),
      .perf_exe   (perf_exe),
      .perf_data  (perf_data),
      .perf_flush (perf_flush)
`endif
   );
   exp_t        exp_q[$];
   logic [31:0] pc_q[$];
   exp_t        e_m;
   int          total = 0, passed = 0;
   bit          draining = 1'b0, pulse = 1'b0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act === want) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
   endtask
   // Reference: stall is the thermometer of the oldest stalled stage; a flush is decided when a
   // nonzero type is present, not shadowed by a pulse, and not blocked by a data-bus stall.
   task automatic step(input bit r, input bit inst, input bit id, input bit exe, input bit data,
                       input logic [31:0] et, input logic [31:0] epc, input bit out, input bit rv);
      exp_t e;
      bit   nxt;
      @(posedge clk);
      #1;
      rst                     = r;
      bus_if.req_inst_stall   = inst;
      bus_if.req_id_stall     = id;
      bus_if.req_exe_stall    = exe;
      bus_if.req_data_stall   = data;
      bus_if.mem_excep_type   = et;
      bus_if.cp0_epc          = epc;
      bus_if.ibus_outstanding = out;
      bus_if.ibus_rvalid      = rv;
      e.stall = data ? 4'b1111 : exe ? 4'b0111 : id ? 4'b0011 : (inst || draining) ? 4'b0001 : 4'b0000;
      e.disc  = draining;
      e.exc   = pulse;
      exp_q.push_back(e);
      if (r) begin
         draining = 1'b0;
         pulse    = 1'b0;
`ifdef PIPE_PERF_CNT_EN
         m_inst = 0; m_id = 0; m_exe = 0; m_data = 0; m_flush = 0;
`endif
      end else begin
`ifdef PIPE_PERF_CNT_EN
         case (e.stall)
            4'b1111: m_data++;
            4'b0111: m_exe++;
            4'b0011: m_id++;
            4'b0001: m_inst++;
            default: ;
         endcase
         if (pulse) m_flush++;
`endif
         nxt = et != 0 && !pulse && (draining || !data);
         if (nxt) begin
            pc_q.push_back(et == ERET ? epc : VEC);
            draining = draining || (out && !rv);
         end else if (rv) draining = 1'b0;
         pulse = nxt;
      end
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, $urandom, 0, 0);
   endtask
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e_m = exp_q.pop_front();
         chk("stall", {28'd0, bus_if.stall}, {28'd0, e_m.stall});
         chk("discard_inst", {31'd0, bus_if.discard_inst}, {31'd0, e_m.disc});
         chk("exception", {31'd0, bus_if.exception}, {31'd0, e_m.exc});
         if (bus_if.exception === 1'b1) begin
            chk("pulse_expected", {31'd0, pc_q.size() > 0}, 32'd1);
            if (pc_q.size() > 0) chk("new_pc", bus_if.new_pc, pc_q.pop_front());
         end
      end
   end
   initial begin
      logic [31:0] held;
      bit          clr, r;
      bus_if.req_inst_stall   = 1'b0;
      bus_if.req_id_stall     = 1'b0;
      bus_if.req_exe_stall    = 1'b0;
      bus_if.req_data_stall   = 1'b0;
      bus_if.mem_excep_type   = '0;
      bus_if.cp0_epc          = '0;
      bus_if.ibus_outstanding = 1'b0;
      bus_if.ibus_rvalid      = 1'b0;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_new_pc", bus_if.new_pc, 32'd0);
`ifdef PIPE_PERF_CNT_EN
      for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 32'h1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 32'h1, 0, 0, 0);
      idle(1);
      chk("perf_exe_5", perf_exe, 32'd5);
      chk("perf_flush_1", perf_flush, 32'd1);
`endif
      step(0, 0, 0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0, 0);
      idle(1);
      step(0, 0, 0, 0, 0, 32'h1, 32'h1234_5678, 0, 0);
      step(0, 0, 0, 0, 0, 32'h1, 32'h1234_5678, 0, 0);
      idle(2);
      step(0, 0, 0, 0, 0, ERET, 32'hBFC01234, 0, 0);
      step(0, 0, 0, 0, 0, ERET, 32'h0, 0, 0);
      idle(2);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 32'h4, 32'h0, 0, 0);
      step(0, 0, 0, 0, 0, 32'h4, 32'h0, 0, 0);
      step(0, 0, 0, 0, 0, 32'h4, 32'h0, 0, 0);
      idle(1);
      step(0, 0, 0, 0, 0, 32'h8, 32'h0, 1, 0);
      step(0, 0, 0, 0, 0, 32'h8, 32'h0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 32'h0, 1, 1);
      idle(2);
      step(0, 0, 0, 0, 0, 32'h10, 32'h0, 1, 0);
      step(0, 0, 0, 0, 0, 32'h10, 32'h0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 32'h0, 1, 0);
      idle(2);
      // Random traffic: a MEM exception type is held until its flush pulse has been seen.
      held = '0;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 299) == 0;
         if (held == 0 && !draining && !pulse && $urandom_range(0, 5) == 0)
            held = ($urandom_range(0, 2) == 0) ? ERET : ($urandom | 32'h1);
         clr = pulse || r;
         step(r, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) == 0, r ? 32'h0 : held, $urandom, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0);
         if (clr) held = '0;
      end
      idle(3);
      @(negedge clk);
      #1;
      chk("pc_queue_drained", pc_q.size(), 32'd0);
      chk("exp_queue_drained", exp_q.size(), 32'd0);
`ifdef PIPE_PERF_CNT_EN
      @(posedge clk);
      #1;
      chk("perf_inst", perf_inst, m_inst);
      chk("perf_id", perf_id, m_id);
      chk("perf_exe", perf_exe, m_exe);
      chk("perf_data", perf_data, m_data);
      chk("perf_flush", perf_flush, m_flush);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
